// File: rtl/memory_access_unit_pkg.sv
// Shared memory-stage constants: bus op codes, funct3 access sizes, FSM states.
package memory_access_unit_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10
    } mau_state_t;

    // Encoding 11 is reserved and behaves like "no memory access".
    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data-memory request/grant/response bus between the memory stage and data memory.
interface memory_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/memory_access_unit_load_store_align.sv
// Combinational lane logic: store strobes/replication, load extraction/extension,
// natural-alignment check.
module load_store_align
    import memory_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  sel,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Size is carried by sel[1:0]; the unsigned bit does not change alignment or lanes.
    always_comb begin
        misaligned = 1'b0;
        wdata      = store_data;
        wstrb      = 4'b1111;
        case (sel[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                misaligned = addr_lo[0];
                wdata      = {2{store_data[15:0]}};
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        load_value = shifted;
        case (sel)
            MEM_B:   load_value = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  load_value = {24'h0, shifted[7:0]};
            MEM_H:   load_value = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  load_value = {16'h0, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I memory stage: runs load/store transactions on the data bus, stalls
// upstream while one is outstanding, and registers results for writeback.
//
// state   | meaning
// IDLE    | accepting a new instruction from execute
// REQ     | bus request held until granted
// WAIT_R  | load granted, waiting for read data
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          rs2_data,
    input  logic [1:0]           mem_op,
    input  logic [2:0]           mem_sel,
    input  logic [1:0]           wb_sel,
    input  logic [4:0]           rd,
    input  logic                 reg_we,
    input  logic [31:0]          pc_next,
    input  logic [31:0]          pc_adder_result,
    output logic                 stall,
    memory_access_unit_if.master dmem,
    output logic                 out_valid,
    output logic [31:0]          load_data,
    output logic [31:0]          alu_result_out,
    output logic [1:0]           wb_sel_out,
    output logic [4:0]           rd_out,
    output logic                 reg_we_out,
    output logic [31:0]          pc_next_out,
    output logic [31:0]          pc_adder_result_out,
    output logic                 misaligned
);

    mau_state_t  state_q, state_d;
    logic        req_c;

    logic [31:0] cap_addr, cap_wdata, cap_pc_next, cap_pc_adder;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_sel;
    logic        cap_load, cap_reg_we;
    logic [1:0]  cap_wb_sel;
    logic [4:0]  cap_rd;

    logic [1:0]  align_addr;
    logic [2:0]  align_sel;
    logic [31:0] align_wdata, align_load;
    logic [3:0]  align_wstrb;
    logic        align_mis;

    logic        take, is_mem_in, mis_in, done_direct, done_store, done_load;

    // In IDLE the aligner looks at the incoming instruction; otherwise at the captured one.
    assign align_addr = (state_q == ST_IDLE) ? alu_result[1:0] : cap_addr[1:0];
    assign align_sel  = (state_q == ST_IDLE) ? mem_sel : cap_sel;

    load_store_align u_align (
        .addr_lo    (align_addr),
        .sel        (align_sel),
        .store_data (rs2_data),
        .rdata      (dmem.dmem_rdata),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .load_value (align_load),
        .misaligned (align_mis)
    );

    assign take        = (state_q == ST_IDLE) && in_valid;
    assign is_mem_in   = is_mem_access(mem_op);
    assign mis_in      = is_mem_in && align_mis;
    assign done_direct = take && !(is_mem_in && !align_mis);
    assign done_store  = (state_q == ST_REQ) && dmem.dmem_gnt && !cap_load;
    assign done_load   = (state_q == ST_WAIT_R) && dmem.dmem_rvalid;

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = req_c && !cap_load;
    assign dmem.dmem_addr  = {cap_addr[31:2], 2'b00};
    assign dmem.dmem_wdata = cap_wdata;
    assign dmem.dmem_wstrb = cap_wstrb;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state, bus request and stall.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && is_mem_in && !align_mis) state_d = ST_REQ;
            end
            ST_REQ: begin
                stall = 1'b1;
                req_c = 1'b1;
                if (dmem.dmem_gnt) state_d = cap_load ? ST_WAIT_R : ST_IDLE;
            end
            ST_WAIT_R: begin
                stall = 1'b1;
                if (dmem.dmem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the instruction; loads carry zero strobes so they never look like writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr     <= '0;
            cap_sel      <= '0;
            cap_load     <= 1'b0;
            cap_wdata    <= '0;
            cap_wstrb    <= '0;
            cap_wb_sel   <= '0;
            cap_rd       <= '0;
            cap_reg_we   <= 1'b0;
            cap_pc_next  <= '0;
            cap_pc_adder <= '0;
        end else if (take) begin
            cap_addr     <= alu_result;
            cap_sel      <= mem_sel;
            cap_load     <= (mem_op == MEM_OP_LOAD);
            cap_wdata    <= (mem_op == MEM_OP_STORE) ? align_wdata : '0;
            cap_wstrb    <= (mem_op == MEM_OP_STORE) ? align_wstrb : '0;
            cap_wb_sel   <= wb_sel;
            cap_rd       <= rd;
            cap_reg_we   <= reg_we;
            cap_pc_next  <= pc_next;
            cap_pc_adder <= pc_adder_result;
        end
    end

    // Writeback-facing results, updated only when an instruction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid           <= 1'b0;
            load_data           <= '0;
            alu_result_out      <= '0;
            wb_sel_out          <= '0;
            rd_out              <= '0;
            reg_we_out          <= 1'b0;
            pc_next_out         <= '0;
            pc_adder_result_out <= '0;
            misaligned          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (done_direct) begin
                out_valid           <= 1'b1;
                load_data           <= '0;
                alu_result_out      <= alu_result;
                wb_sel_out          <= wb_sel;
                rd_out              <= rd;
                reg_we_out          <= reg_we && !mis_in;
                pc_next_out         <= pc_next;
                pc_adder_result_out <= pc_adder_result;
                misaligned          <= mis_in;
            end else if (done_store || done_load) begin
                out_valid           <= 1'b1;
                load_data           <= done_load ? align_load : '0;
                alu_result_out      <= cap_addr;
                wb_sel_out          <= cap_wb_sel;
                rd_out              <= cap_rd;
                reg_we_out          <= cap_reg_we;
                pc_next_out         <= cap_pc_next;
                pc_adder_result_out <= cap_pc_adder;
                misaligned          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed plan items plus randomized ops
// against a behavioural model of the memory stage.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = '0, rs2_data = '0, pc_next = '0, pc_adder_result = '0;
    logic [1:0]  mem_op = '0, wb_sel = '0;
    logic [2:0]  mem_sel = '0;
    logic [4:0]  rd = '0;
    logic        reg_we = 1'b0;
    logic        stall, out_valid, reg_we_out, misaligned;
    logic [31:0] load_data, alu_result_out, pc_next_out, pc_adder_result_out;
    logic [1:0]  wb_sel_out;
    logic [4:0]  rd_out;

    int tests_run = 0;
    int tests_failed = 0;

    // expected completion values for the op in flight
    logic [31:0] e_alu, e_ld, e_pcn, e_pca;
    logic [1:0]  e_wb;
    logic [4:0]  e_rd;
    logic        e_we, e_mis;

    memory_access_unit_if bus();

    memory_access_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .rs2_data(rs2_data), .mem_op(mem_op), .mem_sel(mem_sel), .wb_sel(wb_sel),
        .rd(rd), .reg_we(reg_we), .pc_next(pc_next), .pc_adder_result(pc_adder_result),
        .stall(stall), .dmem(bus), .out_valid(out_valid), .load_data(load_data),
        .alu_result_out(alu_result_out), .wb_sel_out(wb_sel_out), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .pc_next_out(pc_next_out),
        .pc_adder_result_out(pc_adder_result_out), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] sel);
        case (sel)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sel, input int a, input logic [31:0] word);
        int unsigned v;
        v = word >> (8 * a);
        case (sel)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'b101: v = v % 65536;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_wstrb(input int size, input int a);
        int unsigned m;
        m = ((1 << size) - 1) << a;
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
        logic [31:0] w;
        w = '0;
        for (int lane = 0; lane < 4; lane++)
            w = w | (((d >> (8 * (lane % size))) & 32'hFF) << (8 * lane));
        return w;
    endfunction

    task automatic scramble_inputs();
        in_valid        = 1'b1;
        alu_result      = $urandom;
        rs2_data        = $urandom;
        mem_op          = 2'($urandom);
        mem_sel         = 3'($urandom);
        wb_sel          = 2'($urandom);
        rd              = 5'($urandom);
        reg_we          = 1'($urandom);
        pc_next         = $urandom;
        pc_adder_result = $urandom;
    endtask

    task automatic check_done(input string tag);
        chk({tag, ".out_valid"},  out_valid, 1'b1);
        chk({tag, ".load_data"},  load_data, e_ld);
        chk({tag, ".misaligned"}, misaligned, e_mis);
        chk({tag, ".reg_we_out"}, reg_we_out, e_we);
        chk({tag, ".alu_out"},    alu_result_out, e_alu);
        chk({tag, ".wb_sel_out"}, wb_sel_out, e_wb);
        chk({tag, ".rd_out"},     rd_out, e_rd);
        chk({tag, ".pc_next"},    pc_next_out, e_pcn);
        chk({tag, ".pc_adder"},   pc_adder_result_out, e_pca);
    endtask

    // One instruction: capture, optional bus transaction with g REQ cycles and
    // d idle WAIT_R cycles, then check the completion. Returns in the out_valid cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input int g, input int d, input logic [31:0] rdata);
        logic is_mem, mis;
        int   size;
        size   = ref_size(sel);
        is_mem = (op == 2'b01) || (op == 2'b10);
        mis    = is_mem && ((addr % size) != 0);
        in_valid = 1'b1; alu_result = addr; rs2_data = rs2; mem_op = op; mem_sel = sel;
        wb_sel = 2'($urandom); rd = 5'($urandom); reg_we = 1'($urandom);
        pc_next = $urandom; pc_adder_result = $urandom;
        e_alu = addr; e_wb = wb_sel; e_rd = rd; e_pcn = pc_next; e_pca = pc_adder_result;
        e_we  = reg_we && !mis;
        e_mis = mis;
        e_ld  = (op == 2'b01 && !mis) ? ref_load(sel, int'(addr % 4), rdata) : 32'h0;
        @(posedge clk); #1;
        if (!is_mem || mis) begin
            in_valid = 1'b0;
            chk({tag, ".stall"}, stall, 1'b0);
            chk({tag, ".no_req"}, bus.dmem_req, 1'b0);
            check_done(tag);
        end else begin
            chk({tag, ".pulse_end"}, out_valid, 1'b0);
            chk({tag, ".addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".we"}, bus.dmem_we, (op == 2'b10));
            if (op == 2'b10) begin
                chk({tag, ".wstrb"}, bus.dmem_wstrb, ref_wstrb(size, int'(addr % 4)));
                chk({tag, ".wdata"}, bus.dmem_wdata, ref_wdata(size, rs2));
            end
            scramble_inputs();
            for (int i = 0; i < g; i++) begin
                if (i > 0) begin
                    bus.dmem_rvalid = 1'($urandom);
                    @(posedge clk); #1;
                    bus.dmem_rvalid = 1'b0;
                end
                chk({tag, ".req"}, bus.dmem_req, 1'b1);
                chk({tag, ".stall_req"}, stall, 1'b1);
                chk({tag, ".busy_req"}, out_valid, 1'b0);
            end
            bus.dmem_gnt = 1'b1;
            @(posedge clk); #1;
            bus.dmem_gnt = 1'b0;
            if (op == 2'b10) begin
                in_valid = 1'b0;
                chk({tag, ".stall_done"}, stall, 1'b0);
                check_done(tag);
            end else begin
                chk({tag, ".req_drop"}, bus.dmem_req, 1'b0);
                chk({tag, ".stall_wait"}, stall, 1'b1);
                for (int i = 0; i < d; i++) begin
                    bus.dmem_gnt = 1'($urandom);
                    @(posedge clk); #1;
                    bus.dmem_gnt = 1'b0;
                    chk({tag, ".busy_wait"}, out_valid, 1'b0);
                end
                bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
                @(posedge clk); #1;
                bus.dmem_rvalid = 1'b0; bus.dmem_rdata = $urandom;
                in_valid = 1'b0;
                chk({tag, ".stall_done"}, stall, 1'b0);
                check_done(tag);
            end
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [2:0]  load_sels [5];
        load_sels = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", stall, 1'b0);
        chk("rst.req", bus.dmem_req, 1'b0);
        chk("rst.we", bus.dmem_we, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.misaligned", misaligned, 1'b0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.alu_out", alu_result_out, 32'h0);
        chk("rst.pc_next", pc_next_out, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("alu",  2'b00, 3'b010, 32'h0000_1234, 32'h0, 0, 0, 32'h0);
        do_op("sb",   2'b10, 3'b000, 32'h0000_0103, 32'h0000_00AB, 2, 0, 32'h0);
        chk("sb.wstrb_lit", bus.dmem_wstrb, 4'b1000);
        chk("sb.wdata_lit", bus.dmem_wdata, 32'hABAB_ABAB);
        do_op("lb",   2'b01, 3'b000, 32'h0000_0101, 32'h0, 1, 1, 32'h0000_8000);
        chk("lb.lit", load_data, 32'hFFFF_FF80);
        do_op("lbu",  2'b01, 3'b100, 32'h0000_0101, 32'h0, 1, 1, 32'h0000_8000);
        chk("lbu.lit", load_data, 32'h0000_0080);
        do_op("lw_mis", 2'b01, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 32'h0);
        chk("lw_mis.lit", misaligned, 1'b1);

        // reset while waiting for read data
        in_valid = 1'b1; alu_result = 32'h40; mem_op = 2'b01; mem_sel = 3'b010;
        reg_we = 1'b1; rd = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bus.dmem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0;
        chk("rstw.stall_before", stall, 1'b1);
        rst = 1'b1;
        #2;
        chk("rstw.stall_async", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        chk("rstw.out_valid", out_valid, 1'b0);
        chk("rstw.load_data", load_data, 32'h0);
        chk("rstw.alu_out", alu_result_out, 32'h0);
        chk("rstw.rd_out", rd_out, 5'd0);
        chk("rstw.reg_we_out", reg_we_out, 1'b0);
        chk("rstw.stall", stall, 1'b0);
        chk("rstw.req", bus.dmem_req, 1'b0);

        // back-to-back: SW then LH in the SW's completion cycle
        do_op("b2b_sw", 2'b10, 3'b010, 32'h0000_0200, 32'h1234_5678, 1, 0, 32'h0);
        do_op("b2b_lh", 2'b01, 3'b001, 32'h0000_0202, 32'h0, 1, 0, 32'h7FFF_0000);
        chk("b2b_lh.lit", load_data, 32'h0000_7FFF);
        @(posedge clk); #1;
        chk("b2b.pulse_one", out_valid, 1'b0);

        // randomized ops, many issued back-to-back
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom);
            if (op == 2'b10) sel = 3'($urandom_range(0, 2));
            else             sel = load_sels[$urandom_range(0, 4)];
            do_op("rand", op, sel, $urandom, $urandom,
                  $urandom_range(1, 3), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("rand.pulse_one", out_valid, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the execute stage's ALU result, store data, memory op/size and writeback controls.
- Runs load/store transactions on a request/grant/response data-memory bus, aligning and extending load data.
- Stalls upstream while a transaction is outstanding.
- Presents registered results to the writeback stage.

## Interface
Parameters:
- none; address and data width fixed at 32

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute stage presents an instruction
- alu_result  in  32  effective address, or result for non-memory ops
- rs2_data  in  32  store data
- mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- mem_sel  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- wb_sel, rd, reg_we, pc_next, pc_adder_result  in  2/5/1/32/32  writeback controls, passed through
- stall  out  1  hold execute stage and everything upstream
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address, bits[1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- out_valid  out  1  one-cycle pulse, results valid for writeback
- load_data  out  32  aligned, extended load result (0 for non-loads)
- alu_result_out, wb_sel_out, rd_out, reg_we_out, pc_next_out, pc_adder_result_out  out  registered pass-throughs
- misaligned  out  1  valid with out_valid; access violated natural alignment

## Operation
- Alignment rule: H/HU requires addr[0]=0; W requires addr[1:0]=0.
- FSM states:
  - IDLE: on in_valid, capture all inputs. Go to REQ for an aligned load/store. Otherwise return the result next cycle and stay in IDLE. mem_op none does not check alignment.
  - REQ: dmem_req=1 with captured address, data and strobes, held stable until dmem_gnt. On gnt: a store completes and goes to IDLE; a load goes to WAIT_R.
  - WAIT_R: dmem_req=0. On dmem_rvalid, latch the aligned/extended word and go to IDLE.
- stall = (state==REQ) | (state==WAIT_R). Inputs are ignored outside IDLE; upstream holds them while stall is high.
- Store data and strobes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 or 1100, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111.
- Load: select byte/half by the captured addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Misaligned access:
  - No bus request is issued.
  - out_valid fires 1 cycle later with misaligned=1, reg_we_out=0, load_data=0.
- dmem_rvalid in IDLE or REQ is ignored. dmem_gnt outside REQ is ignored.

## Timing
- Reset: state IDLE; stall, dmem_req, dmem_we, out_valid, misaligned = 0; all data/pass-through outputs = 0. Reset mid-transaction abandons it, with no out_valid. Later rvalid is ignored.
- Non-memory or misaligned op: capture at edge N, out_valid high during cycle N+1.
- Store with gnt after g cycles in REQ (g≥1): out_valid is high the cycle after gnt; stall is low in that cycle.
- Load: rvalid arrives no earlier than the cycle after gnt. out_valid is high the cycle after rvalid. Minimum load latency is 3 cycles from capture.
- out_valid is exactly one cycle; outputs hold their values until the next completion.
- Back-to-back operation: when stall is low in a cycle, IDLE may capture a new instruction. This is allowed in the same cycle out_valid is high for the previous instruction.

## Structure
- Shared package/header holds:
  - MEM_OP_NONE/LOAD/STORE
  - funct3 size codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
  - FSM state encodings
  These constants are shared with the decoder and execute stage.
- Sub-module `load_store_align` is purely combinational and contains:
  - the store lane/strobe generator
  - the load extractor/extender
  - the misalignment check
- The FSM and registers stay in the top module.

## Test plan
- ALU op, alu_result=0x1234, mem_op=00 → out_valid the next cycle; alu_result_out=0x1234; stall never high.
- SB, addr=0x103, rs2=0xAB, gnt after 2 REQ cycles → dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB; stall high for 2 cycles; out_valid the cycle after gnt.
- LB/LBU, addr=0x101, rdata=0x00008000 returned 2 cycles after gnt → LB load_data=0xFFFFFF80; LBU load_data=0x00000080.
- LW at 0x102 → no dmem_req; out_valid the next cycle with misaligned=1, reg_we_out=0.
- Assert rst during WAIT_R, then rvalid after release → all outputs 0; no out_valid; FSM in IDLE.
- Back-to-back: SW with immediate gnt, then LH at 0x202 with rdata=0x7FFF0000 → two out_valid pulses in order; second load_data=0x00007FFF.
